// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one req/gnt/rvalid memory port between the fetch and
//               load/store ports. Grants are locked to the selected port
//               across gnt wait states. Granted-but-unanswered transactions
//               are tracked in an in-order ID FIFO so that responses are
//               routed back to the port that issued them.
//               Optional feature macro: MEM_ARB_RR_EN (round-robin on ties;
//               fixed data-over-instr priority when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // instruction fetch port
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    // load/store port
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    // shared memory port
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    // status
    output logic                    busy_o,
    output logic                    rsp_err_o
);

    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        LOCK_NONE  = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_DATA  = 2'd2
    } lock_t;

    lock_t                      r_lock;
    lock_t                      w_lock_nxt;
    logic                       w_sel_valid;
    logic                       w_sel_data;    // 1 = data port selected
    logic                       w_full;
    logic                       w_empty;
    logic                       w_mem_req;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_head;
    logic                       w_last_data;

    logic [MAX_OUTSTANDING-1:0] r_ids;
    logic [c_PTR_W-1:0]         r_wptr;
    logic [c_PTR_W-1:0]         r_rptr;
    logic [c_CNT_W-1:0]         r_count;
    logic                       r_err;

    // Advance a FIFO pointer, wrapping at MAX_OUTSTANDING.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef MEM_ARB_RR_EN
    logic r_last_data;

    // Remember which port completed the most recent handshake; data at reset
    // so the first tie goes to instr.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_data <= 1'b1;
        end else if (w_push) begin
            r_last_data <= w_sel_data;
        end
    end

    assign w_last_data = r_last_data;
`else
    assign w_last_data = 1'b0;
`endif

    assign w_full    = (r_count == c_CNT_W'(MAX_OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_mem_req = w_sel_valid && !w_full;
    assign w_push    = w_mem_req && mem_gnt_i;
    assign w_pop     = mem_rvalid_i && !w_empty;
    assign w_head    = r_ids[r_rptr];

    // Lock state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock <= LOCK_NONE;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end

    // Port selection and lock next-state: a held lock forwards only its port.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = 1'b0;
        w_lock_nxt  = r_lock;
        case (r_lock)
            LOCK_INSTR: begin
                w_sel_valid = instr_req_i;
                w_sel_data  = 1'b0;
            end
            LOCK_DATA: begin
                w_sel_valid = data_req_i;
                w_sel_data  = 1'b1;
            end
            default: begin
                if (instr_req_i && data_req_i) begin
                    w_sel_valid = 1'b1;
`ifdef MEM_ARB_RR_EN
                    w_sel_data  = !w_last_data;
`else
                    w_sel_data  = 1'b1;
`endif
                end else if (instr_req_i) begin
                    w_sel_valid = 1'b1;
                    w_sel_data  = 1'b0;
                end else if (data_req_i) begin
                    w_sel_valid = 1'b1;
                    w_sel_data  = 1'b1;
                end
            end
        endcase

        if (r_lock == LOCK_NONE) begin
            if (w_mem_req && !mem_gnt_i) begin
                w_lock_nxt = w_sel_data ? LOCK_DATA : LOCK_INSTR;
            end
        end else if (w_push) begin
            w_lock_nxt = LOCK_NONE;
        end
    end

    // Response-ID FIFO and the sticky unexpected-response flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ids   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= w_sel_data;
                r_wptr        <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (mem_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Request mux: fetches are full-word reads.
    assign mem_req_o   = w_mem_req;
    assign mem_we_o    = w_sel_data ? data_we_i : 1'b0;
    assign mem_be_o    = w_sel_data ? data_be_i : {(DATA_WIDTH/8){1'b1}};
    assign mem_addr_o  = w_sel_data ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = data_wdata_i;

    assign instr_gnt_o = w_mem_req && !w_sel_data && mem_gnt_i;
    assign data_gnt_o  = w_mem_req &&  w_sel_data && mem_gnt_i;

    // Response routing by FIFO head; unexpected responses are dropped.
    assign instr_rvalid_o = w_pop && !w_head;
    assign data_rvalid_o  = w_pop &&  w_head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign busy_o    = !w_empty;
    assign rsp_err_o = r_err;

endmodule
`default_nettype wire
